// File: rtl/header_ram_reader_pkg.sv
// Shared definitions for the header RAM readout sequencer.
package header_ram_reader_pkg;

  // Default number of output buffer entries (power of 2, at least 4).
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/header_out_fifo.sv
// Small synchronous FIFO carrying {last, data} between the RAM capture
// point and the valid/ready output stream. Head entry is presented directly.
module header_out_fifo
  import header_ram_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  assign rd_valid = (count_q != {CW{1'b0}});
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_s   = (count_q == CW'(DEPTH));
    pop_s    = rd_valid & rd_ready;
    push_s   = wr_en & (~full_s | pop_s);
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers; storage is cleared on reset so outputs read 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  header_out_fifo_chk u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (wr_en),
    .pop     (pop_s),
    .full    (full_s)
  );

endmodule

// File: rtl/header_out_fifo_chk.sv
// Assertion checker for the header output buffer: a write may never land
// in a full buffer unless the head entry leaves in the same cycle.
module header_out_fifo_chk (
  input logic clock,
  input logic reset_n,
  input logic flush,
  input logic push,
  input logic pop,
  input logic full
);

  // Flag any write attempted into a full buffer that is not being drained.
  always @(posedge clock) begin
    if (reset_n && !flush) begin
      assert (!(push && full && !pop))
        else $error("header_out_fifo: push into full buffer");
    end
  end

endmodule

// File: rtl/header_ram_reader.sv
// Readout sequencer for the header RAM read port: issues consecutive reads,
// captures the 1-clock-latency data into a credit-controlled buffer and
// streams the words out with valid/ready and a last marker.
module header_ram_reader
  import header_ram_reader_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 18,
  parameter int unsigned RAM_ADRB   = 11,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [RAM_ADRB-1:0]  start_adr,
  input  logic [RAM_ADRB:0]    nwords,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_enb,
  output logic [RAM_ADRB-1:0]  rd_adrb,
  input  logic [RAM_WIDTH-1:0] rd_datab,
  output logic [RAM_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NW = RAM_ADRB + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  rd_state_e           state_q, state_d;
  logic [RAM_ADRB-1:0] adr_q, adr_d;
  logic [NW-1:0]       nwords_q, nwords_d;
  logic [NW-1:0]       issued_q, issued_d;
  logic                pending_q, pending_d;
  logic                pend_last_q, pend_last_d;

  logic [CW-1:0]       fifo_count_s;
  logic [CW:0]         credits_used_s;
  logic                credit_ok_s;
  logic                flush_s;
  logic [NW-1:0]       issued_inc_s;
  logic [RAM_WIDTH:0]  fifo_rd_s;

  assign out_data = fifo_rd_s[RAM_WIDTH-1:0];
  assign out_last = fifo_rd_s[RAM_WIDTH];
  assign rd_adrb  = adr_q;
  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // FSM next state, read issue and credit check (registered counts only).
  always_comb begin
    state_d        = state_q;
    adr_d          = adr_q;
    nwords_d       = nwords_q;
    issued_d       = issued_q;
    pending_d      = 1'b0;
    pend_last_d    = 1'b0;
    rd_enb         = 1'b0;
    flush_s        = 1'b0;
    credits_used_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, pending_q};
    credit_ok_s    = (credits_used_s < DEPTH_C);
    issued_inc_s   = issued_q + {{(NW-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          adr_d    = start_adr;
          nwords_d = nwords;
          issued_d = {NW{1'b0}};
          if (nwords == {NW{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
          flush_s = 1'b1;
        end else if (credit_ok_s && (issued_q != nwords_q)) begin
          rd_enb      = 1'b1;
          adr_d       = adr_q + {{(RAM_ADRB-1){1'b0}}, 1'b1};
          issued_d    = issued_inc_s;
          pending_d   = 1'b1;
          pend_last_d = (issued_inc_s == nwords_q);
          if (issued_inc_s == nwords_q) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          flush_s = 1'b1;
        end else if (out_valid && out_ready && out_last) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        flush_s = 1'b1;
      end
    endcase
  end

  // Sequencer registers: state, address/issue counters and capture flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      adr_q       <= {RAM_ADRB{1'b0}};
      nwords_q    <= {NW{1'b0}};
      issued_q    <= {NW{1'b0}};
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      nwords_q    <= nwords_d;
      issued_q    <= issued_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
    end
  end

  // RAM data is captured only in the cycle following an issue; a flush
  // on abort overrides that capture.
  header_out_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush_s),
    .wr_en    (pending_q),
    .wr_data  ({pend_last_q, rd_datab}),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (fifo_rd_s),
    .count    (fifo_count_s)
  );

endmodule

// File: tb/tb_header_ram_reader.sv
// Directed bench for header_ram_reader with a 1-clock registered-read RAM model.
module tb_header_ram_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] start_adr = 11'd0;
  logic [11:0] nwords = 12'd0;
  logic        abort = 1'b0;
  logic        busy, done, rd_enb;
  logic [10:0] rd_adrb;
  logic [17:0] rd_datab = 18'd0;
  logic [17:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  header_ram_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .start_adr (start_adr),
    .nwords    (nwords),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_enb    (rd_enb),
    .rd_adrb   (rd_adrb),
    .rd_datab  (rd_datab),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  // Header RAM contents: distinct word per address.
  function automatic logic [17:0] ram_word(input logic [10:0] a);
    return {a[6:0] ^ 7'h5A, a};
  endfunction

  // RAM port B model: registered read, output held when not enabled.
  always @(posedge clock) begin
    if (rd_enb) rd_datab <= ram_word(rd_adrb);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One readout; mode 0: ready=1, mode 1: ready=0 for 'stall' cycles, mode 2: random ready.
  task automatic run_read(input logic [10:0] adr, input logic [11:0] n, input int mode, input int stall);
    int          issues, got, last_hs, budget;
    bit          fin, stalled;
    logic [17:0] pd;
    logic        pl;
    logic [10:0] ea;
    issues = 0; got = 0; last_hs = 0; fin = 0; stalled = 0; pd = 18'd0; pl = 1'b0;
    budget = 32'(n) * 4 + 100;
    @(negedge clock);
    start = 1'b1; start_adr = adr; nwords = n; out_ready = (mode == 0);
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_last", 32'(out_last), 32'(pl));
      end
      if (rd_enb) begin
        ea = adr + 11'(issues);
        chk("rd_adrb", 32'(rd_adrb), 32'(ea));
        if (mode == 0) chk("issue_cycle", cyc, issues + 1);
        issues++;
      end
      if (mode == 1 && cyc == stall) chk("issues_stalled", issues, (32'(n) < 4) ? 32'(n) : 32'd4);
      if (done) begin
        chk("done_count", got, 32'(n));
        chk("done_cycle", cyc, last_hs + 1);
        if (mode == 0) chk("done_latency", cyc, 32'(n) + 3);
        chk("busy_in_done", 32'(busy), 32'd0);
        fin = 1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc > stall);
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (mode == 0 && got == 0 && out_valid) chk("first_valid_cycle", cyc, 32'd3);
        if (out_valid && out_ready) begin
          ea = adr + 11'(got);
          chk("data", 32'(out_data), 32'(ram_word(ea)));
          chk("last", 32'(out_last), 32'(got == 32'(n) - 1));
          got++;
          last_hs = cyc;
        end
        stalled = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
      end
    end
    chk("done_seen", 32'(fin), 32'd1);
    chk("issue_total", issues, 32'(n));
    @(negedge clock);
    out_ready = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int   got;
    bit   hit;
    logic [10:0] ea;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_enb", 32'(rd_enb), 32'd0);
    chk("rst_rd_adrb", 32'(rd_adrb), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // 1. Basic readout, 2. address wrap, 3. backpressure
    run_read(11'h010, 12'd4, 0, 0);
    run_read(11'h7FE, 12'd4, 0, 0);
    run_read(11'h020, 12'd16, 1, 20);

    // 4. Zero-length readout, start during DONE ignored
    @(negedge clock);
    start = 1'b1; start_adr = 11'h055; nwords = 12'd0;
    @(negedge clock);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_rd_enb", 32'(rd_enb), 32'd0);
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    start = 1'b1; start_adr = 11'h066; nwords = 12'd5;
    @(negedge clock);
    start = 1'b0;
    chk("ign_done", 32'(done), 32'd0);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_rd_enb", 32'(rd_enb), 32'd0);
    @(negedge clock);
    chk("ign_busy2", 32'(busy), 32'd0);
    chk("ign_valid", 32'(out_valid), 32'd0);

    // 5. Full-RAM readout with random backpressure
    run_read(11'h000, 12'd2048, 2, 0);

    // 6. Abort at the 5th word of a 10-word readout
    @(negedge clock);
    start = 1'b1; start_adr = 11'h200; nwords = 12'd10; out_ready = 1'b1;
    got = 0; hit = 0;
    for (int cyc = 1; cyc <= 60 && !hit; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (out_valid) begin
        if (got == 4) begin
          abort = 1'b1;
          hit = 1;
        end else begin
          ea = 11'h200 + 11'(got);
          chk("abort_run_data", 32'(out_data), 32'(ram_word(ea)));
          got++;
        end
      end
    end
    chk("abort_reached", 32'(hit), 32'd1);
    @(negedge clock);
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rd_enb", 32'(rd_enb), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // Reset pulse mid-run
    @(negedge clock);
    start = 1'b1; start_adr = 11'h300; nwords = 12'd10; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("midrun_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rd_enb", 32'(rd_enb), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_rd_adrb", 32'(rd_adrb), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mrst_after_busy", 32'(busy), 32'd0);
    chk("mrst_after_valid", 32'(out_valid), 32'd0);

    run_read(11'h100, 12'd3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
